// File: rtl/y86_fetch_pipe.sv
// rtl/y86_fetch_pipe.sv - Y86-64 pipelined fetch stage with PC, predictor, run/wait/halt FSM and F/D register
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module y86_fetch_pipe #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [79:0]       imem_data_i,
   input  logic              imem_error_i,
   input  logic              stall_i,
   input  logic              bubble_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              d_valid_o,
   output logic [3:0]        d_icode_o,
   output logic [3:0]        d_ifun_o,
   output logic [3:0]        d_rA_o,
   output logic [3:0]        d_rB_o,
   output logic [63:0]       d_valC_o,
   output logic [ADDR_W-1:0] d_valP_o,
   output logic [1:0]        d_stat_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_fetch_cnt_o,
   output logic [31:0]       perf_bubble_cnt_o,
`endif
   output logic [ADDR_W-1:0] pred_pc_o
);

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   typedef enum logic [1:0] {S_RUN, S_WAIT_RET, S_HALT} state_t;

   typedef struct packed {
      logic              valid;
      logic [3:0]        icode;
      logic [3:0]        ifun;
      logic [3:0]        ra;
      logic [3:0]        rb;
      logic [63:0]       valc;
      logic [ADDR_W-1:0] valp;
      logic [1:0]        stat;
   } fd_t;

   localparam fd_t FD_BUBBLE = '{valid: 1'b0, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                 valc: 64'd0, valp: '0, stat: STAT_AOK};

   logic [ADDR_W-1:0] pc_q, pc_d;
   state_t            state_q, state_d;
   fd_t               fd_q, fd_d;
   fd_t               dec;
   logic              fd_load;

   logic [3:0]        icode, ifun, len;
   logic              ifun_ok;
   logic [ADDR_W-1:0] valp, pred_pc;

   assign icode = imem_data_i[7:4];
   assign ifun  = imem_data_i[3:0];

   always_comb begin
      len       = 4'd1;
      ifun_ok   = (ifun == 4'h0);
      dec       = FD_BUBBLE;
      dec.valid = 1'b1;
      dec.icode = icode;
      dec.ifun  = ifun;
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin
            len    = 4'd2;
            dec.ra = imem_data_i[15:12];
            dec.rb = imem_data_i[11:8];
         end
         4'h3, 4'h4, 4'h5: begin
            len      = 4'd10;
            dec.ra   = imem_data_i[15:12];
            dec.rb   = imem_data_i[11:8];
            dec.valc = imem_data_i[79:16];
         end
         4'h7, 4'h8: begin
            len      = 4'd9;
            dec.valc = imem_data_i[71:8];
         end
         default: len = 4'd1;
      endcase
      case (icode)
         4'h2, 4'h7: ifun_ok = (ifun <= 4'd6);
         4'h6:       ifun_ok = (ifun <= 4'd3);
         default:    ifun_ok = (ifun == 4'h0);
      endcase
      valp     = pc_q + {{(ADDR_W-4){1'b0}}, len};
      dec.valp = valp;
      // Memory fault outranks an illegal encoding; halt only counts for a clean fetch.
      if (imem_error_i)                     dec.stat = STAT_ADR;
      else if (icode > 4'hB || !ifun_ok)    dec.stat = STAT_INS;
      else if (icode == 4'h0)               dec.stat = STAT_HLT;
      else                                  dec.stat = STAT_AOK;
      pred_pc = (icode == 4'h7 || icode == 4'h8) ? dec.valc[ADDR_W-1:0] : valp;
   end

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      fd_d    = fd_q;
      fd_load = 1'b0;
      if (redirect_valid_i) begin
         pc_d    = redirect_pc_i;
         state_d = S_RUN;
         fd_d    = FD_BUBBLE;
         fd_load = 1'b1;
      end else if (stall_i) begin
         if (bubble_i) begin
            fd_d    = FD_BUBBLE;
            fd_load = 1'b1;
         end
      end else begin
         fd_load = 1'b1;
         fd_d    = FD_BUBBLE;
         if (state_q == S_RUN) begin
            pc_d = pred_pc;
            fd_d = dec;
            if (dec.stat != STAT_AOK) state_d = S_HALT;
            else if (icode == 4'h9)   state_d = S_WAIT_RET;
         end
         // An external bubble squashes the load but the PC/FSM still advance.
         if (bubble_i) fd_d = FD_BUBBLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q    <= RESET_PC;
         state_q <= S_RUN;
         fd_q    <= FD_BUBBLE;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         fd_q    <= fd_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else if (fd_load) begin
         if (fd_d.valid) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
         else            bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o  = fetch_cnt_q;
   assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

   assign imem_addr_o = pc_q;
   assign pred_pc_o   = pred_pc;
   assign d_valid_o   = fd_q.valid;
   assign d_icode_o   = fd_q.icode;
   assign d_ifun_o    = fd_q.ifun;
   assign d_rA_o      = fd_q.ra;
   assign d_rB_o      = fd_q.rb;
   assign d_valC_o    = fd_q.valc;
   assign d_valP_o    = fd_q.valp;
   assign d_stat_o    = fd_q.stat;

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// tb/tb_y86_fetch_pipe.sv - self-checking bench for y86_fetch_pipe: decode vector table plus pipeline sequences
module tb_y86_fetch_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] imem_addr;
   logic [79:0] win;
   logic        err;
   logic        stall, bubble, redir;
   logic [63:0] redir_pc;
   logic        d_valid;
   logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
   logic [63:0] d_valc, d_valp, pred_pc;
   logic [1:0]  d_stat;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_bubble;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   y86_fetch_pipe #(.ADDR_W(64), .RESET_PC(64'd0)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .imem_addr_o      (imem_addr),
      .imem_data_i      (win),
      .imem_error_i     (err),
      .stall_i          (stall),
      .bubble_i         (bubble),
      .redirect_valid_i (redir),
      .redirect_pc_i    (redir_pc),
      .d_valid_o        (d_valid),
      .d_icode_o        (d_icode),
      .d_ifun_o         (d_ifun),
      .d_rA_o           (d_ra),
      .d_rB_o           (d_rb),
      .d_valC_o         (d_valc),
      .d_valP_o         (d_valp),
      .d_stat_o         (d_stat),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_cnt_o (perf_fetch),
      .perf_bubble_cnt_o(perf_bubble),
`endif
      .pred_pc_o        (pred_pc)
   );

   typedef struct {
      logic [63:0] pc;
      logic [79:0] be;
      logic        err;
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp;
      logic [1:0]  stat;
      logic [63:0] pred;
   } vec_t;

   vec_t vt [18];

   // Stimulus literals list byte 0 first; the memory bus wants byte 0 in bits [7:0].
   function automatic logic [79:0] rev(input logic [79:0] be);
      logic [79:0] r;
      for (int k = 0; k < 10; k++) r[8*k +: 8] = be[8*(9-k) +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble(input string name, input logic [63:0] addr);
      chk({name, " valid"}, 64'(d_valid), 64'd0);
      chk({name, " icode"}, 64'(d_icode), 64'h1);
      chk({name, " addr"}, imem_addr, addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{64'h100, 80'h10000000000000000000, 1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 2'd0, 64'h101};
      vt[1]  = '{64'h200, 80'h21120000000000000000, 1'b0, 4'h2, 4'h1, 4'h1, 4'h2, 64'h0, 64'h202, 2'd0, 64'h202};
      vt[2]  = '{64'h210, 80'h63450000000000000000, 1'b0, 4'h6, 4'h3, 4'h4, 4'h5, 64'h0, 64'h212, 2'd0, 64'h212};
      vt[3]  = '{64'h220, 80'h40350800000000000000, 1'b0, 4'h4, 4'h0, 4'h3, 4'h5, 64'h8, 64'h22A, 2'd0, 64'h22A};
      vt[4]  = '{64'h230, 80'h5067FFFFFFFFFFFFFFFF, 1'b0, 4'h5, 4'h0, 4'h6, 4'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h23A, 2'd0, 64'h23A};
      vt[5]  = '{64'h300, 80'h80000400000000000000, 1'b0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h400, 64'h309, 2'd0, 64'h400};
      vt[6]  = '{64'h020, 80'h70400000000000000000, 1'b0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 2'd0, 64'h40};
      vt[7]  = '{64'h310, 80'h74341200000000000000, 1'b0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h1234, 64'h319, 2'd0, 64'h1234};
      vt[8]  = '{64'h320, 80'hA08F0000000000000000, 1'b0, 4'hA, 4'h0, 4'h8, 4'hF, 64'h0, 64'h322, 2'd0, 64'h322};
      vt[9]  = '{64'h330, 80'hB02F0000000000000000, 1'b0, 4'hB, 4'h0, 4'h2, 4'hF, 64'h0, 64'h332, 2'd0, 64'h332};
      vt[10] = '{64'h340, 80'hC0000000000000000000, 1'b0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h341, 2'd3, 64'h341};
      vt[11] = '{64'h350, 80'h67120000000000000000, 1'b0, 4'h6, 4'h7, 4'h1, 4'h2, 64'h0, 64'h352, 2'd3, 64'h352};
      vt[12] = '{64'h360, 80'h30F20500000000000000, 1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'h36A, 2'd2, 64'h36A};
      vt[13] = '{64'h370, 80'h00000000000000000000, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h371, 2'd1, 64'h371};
      vt[14] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h10000000000000000000, 1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 2'd0, 64'h0};
      vt[15] = '{64'h380, 80'h90000000000000000000, 1'b0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h381, 2'd0, 64'h381};
      vt[16] = '{64'h390, 80'h27000000000000000000, 1'b0, 4'h2, 4'h7, 4'h0, 4'h0, 64'h0, 64'h392, 2'd3, 64'h392};
      vt[17] = '{64'h3A0, 80'hC0000000000000000000, 1'b1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h3A1, 2'd2, 64'h3A1};

      rst_n = 1'b0; err = 1'b0; stall = 1'b0; bubble = 1'b0; redir = 1'b0; redir_pc = 64'd0;
      win = rev(80'h30F00001000000000000);
      step(); step();
      chk("rst valid", 64'(d_valid), 64'd0);
      chk("rst icode", 64'(d_icode), 64'h1);
      chk("rst ifun",  64'(d_ifun), 64'h0);
      chk("rst rA",    64'(d_ra), 64'hF);
      chk("rst rB",    64'(d_rb), 64'hF);
      chk("rst valC",  d_valc, 64'h0);
      chk("rst valP",  d_valp, 64'h0);
      chk("rst stat",  64'(d_stat), 64'd0);
      chk("rst addr",  imem_addr, 64'h0);

      rst_n = 1'b1;
      step();
      chk("irmov valid", 64'(d_valid), 64'd1);
      chk("irmov icode", 64'(d_icode), 64'h3);
      chk("irmov rA",    64'(d_ra), 64'hF);
      chk("irmov rB",    64'(d_rb), 64'h0);
      chk("irmov valC",  d_valc, 64'h100);
      chk("irmov valP",  d_valp, 64'd10);
      chk("irmov stat",  64'(d_stat), 64'd0);
      chk("irmov addr",  imem_addr, 64'd10);

      for (int i = 0; i < 18; i++) begin
         redir = 1'b1; redir_pc = vt[i].pc;
         step();
         redir = 1'b0;
         win = rev(vt[i].be); err = vt[i].err;
         #1;
         chk($sformatf("v%0d addr", i), imem_addr, vt[i].pc);
         chk($sformatf("v%0d pred", i), pred_pc, vt[i].pred);
         step();
         chk($sformatf("v%0d valid", i), 64'(d_valid), 64'd1);
         chk($sformatf("v%0d icode", i), 64'(d_icode), 64'(vt[i].icode));
         chk($sformatf("v%0d ifun", i),  64'(d_ifun), 64'(vt[i].ifun));
         chk($sformatf("v%0d rA", i),    64'(d_ra), 64'(vt[i].ra));
         chk($sformatf("v%0d rB", i),    64'(d_rb), 64'(vt[i].rb));
         chk($sformatf("v%0d valC", i),  d_valc, vt[i].valc);
         chk($sformatf("v%0d valP", i),  d_valp, vt[i].valp);
         chk($sformatf("v%0d stat", i),  64'(d_stat), 64'(vt[i].stat));
         chk($sformatf("v%0d next", i),  imem_addr, vt[i].pred);
         err = 1'b0;
      end

      // jmp at 0x20, then ret at 0x40 held three cycles, then redirect to 0x60
      redir = 1'b1; redir_pc = 64'h20;
      step();
      redir = 1'b0; win = rev(80'h70400000000000000000);
      step();
      chk("jmp next addr", imem_addr, 64'h40);
      win = rev(80'h90000000000000000000);
      step();
      chk("ret icode", 64'(d_icode), 64'h9);
      chk("ret valid", 64'(d_valid), 64'd1);
      chk("ret addr",  imem_addr, 64'h41);
      for (int c = 0; c < 3; c++) begin
         step();
         chk_bubble($sformatf("wait%0d", c), 64'h41);
      end
      redir = 1'b1; redir_pc = 64'h60;
      step();
      chk_bubble("redir edge", 64'h60);
      redir = 1'b0; win = rev(80'h10000000000000000000);
      step();
      chk("redir+2 valid", 64'(d_valid), 64'd1);
      chk("redir+2 valP",  d_valp, 64'h61);

      // stall, stall+bubble, bubble alone
      win = rev(80'h60120000000000000000);
      step();
      chk("addq valP", d_valp, 64'h63);
      win = rev(80'h20340000000000000000);
      stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk($sformatf("stall%0d icode", c), 64'(d_icode), 64'h6);
         chk($sformatf("stall%0d valP", c),  d_valp, 64'h63);
         chk($sformatf("stall%0d addr", c),  imem_addr, 64'h63);
      end
      bubble = 1'b1;
      step();
      chk_bubble("stall+bubble", 64'h63);
      stall = 1'b0;
      step();
      chk_bubble("bubble alone", 64'h65);
      bubble = 1'b0; win = rev(80'h10000000000000000000);
      step();
      chk("after bubble valid", 64'(d_valid), 64'd1);
      chk("after bubble valP",  d_valp, 64'h66);

      // halt enters HALT; redirect with stall recovers
      win = rev(80'h00000000000000000000);
      step();
      chk("halt stat",  64'(d_stat), 64'd1);
      chk("halt valid", 64'(d_valid), 64'd1);
      chk("halt addr",  imem_addr, 64'h67);
      step();
      chk_bubble("halted0", 64'h67);
      step();
      chk_bubble("halted1", 64'h67);
      redir = 1'b1; stall = 1'b1; redir_pc = 64'h80;
      step();
      chk_bubble("redir+stall", 64'h80);
      redir = 1'b0; stall = 1'b0; win = rev(80'h10000000000000000000);
      step();
      chk("resume valid", 64'(d_valid), 64'd1);
      chk("resume valP",  d_valp, 64'h81);

      // asynchronous reset mid-fetch
      #2 rst_n = 1'b0;
      #1;
      chk_bubble("async rst", 64'h0);
      step();
      rst_n = 1'b1;

      // INS enters HALT
      win = rev(80'hC0000000000000000000);
      step();
      chk("ins stat",  64'(d_stat), 64'd3);
      chk("ins icode", 64'(d_icode), 64'hC);
      step();
      chk_bubble("ins halted", 64'h1);

      // ADR enters HALT
      redir = 1'b1; redir_pc = 64'h90;
      step();
      redir = 1'b0; err = 1'b1; win = rev(80'h10000000000000000000);
      step();
      chk("adr stat", 64'(d_stat), 64'd2);
      err = 1'b0;
      step();
      chk_bubble("adr halted", 64'h91);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_fetch_pipe.md
# y86_fetch_pipe

Pipelined Y86-64 fetch stage: owns the PC register, reads a 10-byte instruction window from an external instruction memory, decodes the fields, predicts the next PC and loads a registered F/D pipeline register. It replaces the combinational single-cycle fetch. It adds stall/bubble control, redirect for mispredicts and `ret`, and a run/wait/halt state machine that stops fetching after `ret`, `halt` or any faulting instruction.

## Interface
- ADDR_W, 64, PC / address width; valP, predicted PC and redirect PC use this width.
- RESET_PC, 0, PC value loaded at reset.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- imem_addr_o  out  ADDR_W  fetch address; always equals the PC register.
- imem_data_i  in  80  bytes PC..PC+9; byte 0 is bits [7:0].
- imem_error_i  in  1  any byte of the instruction is out of range.
- stall_i  in  1  hold PC, state and F/D register.
- bubble_i  in  1  load a bubble into the F/D register.
- redirect_valid_i  in  1  load redirect_pc_i into PC and resume.
- redirect_pc_i  in  ADDR_W  corrected PC (mispredict target or `ret` address).
- d_valid_o  out  1  F/D register holds a real instruction.
- d_icode_o, d_ifun_o, d_rA_o, d_rB_o  out  4 each  decoded fields.
- d_valC_o  out  64  constant word, little-endian.
- d_valP_o  out  ADDR_W  PC + instruction length.
- d_stat_o  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS.
- pred_pc_o  out  ADDR_W  predicted next PC (combinational, current fetch).

## Operation
- **Length**
  - 1 byte: halt(0), nop(1), ret(9).
  - 2 bytes: cmov(2), OPq(6), pushq(A), popq(B).
  - 9 bytes: jXX(7), call(8).
  - 10 bytes: irmovq(3), rmmovq(4), mrmovq(5).
- **Register IDs**
  - icodes 2,3,4,5,6,A,B take rA/rB from byte 1, rA in the high nibble.
  - All other icodes use 0xF for both.
- **valC**
  - Bytes 2..9 for icodes 3,4,5.
  - Bytes 1..8 for icodes 7,8.
  - 0 otherwise.
- **Validity**
  - ifun ranges: 0–6 for icodes 2 and 7; 0–3 for icode 6; 0 for all others.
  - icode > 0xB or ifun out of range gives INS.
  - imem_error_i gives ADR, which takes priority over INS.
  - icode 0 gives HLT.
- **valP**: PC + length, modulo 2^ADDR_W.
- **Prediction**: pred_pc = valC[ADDR_W-1:0] for icodes 7 and 8; otherwise valP.
- **Bubble content**: valid 0, icode 1, ifun 0, rA/rB F, valC 0, valP 0, stat AOK.
- **FSM states**
  - RUN: fetch; PC <= pred_pc; F/D register gets the decoded instruction.
    - On ret with AOK: go to WAIT_RET.
    - On stat ≠ AOK: go to HALT.
  - WAIT_RET: PC held; F/D register gets bubbles.
  - HALT: PC held; F/D register gets bubbles.
  - Only a redirect leaves WAIT_RET or HALT.
- **Priority, each cycle**
  - Reset, then redirect, then stall, then normal operation.
  - Redirect: PC <= redirect_pc_i, state <= RUN, F/D register <= bubble. This applies even when stall_i is high.
  - Stall: PC, state and F/D register all hold.
  - bubble_i with stall_i: PC and state hold, F/D register <= bubble.
  - bubble_i alone: PC and state advance normally, but the F/D register gets a bubble.

## Timing
- Reset values:
  - PC = RESET_PC; state = RUN.
  - F/D register = bubble (d_valid_o 0, d_icode_o 1, d_rA_o/d_rB_o F, others 0).
- imem_addr_o is driven from the PC register; imem_data_i and imem_error_i are sampled in the same cycle (combinational memory).
- Latency: an instruction at PC appears on the d_* outputs one clock after PC is presented.
- Redirect: the instruction at redirect_pc_i reaches d_* two edges after the redirect edge.
- Reset asserted mid-fetch clears everything immediately; no partial update survives.
- pred_pc_o is combinational from PC and imem_data_i.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs.
  - perf_fetch_cnt_o [31:0] increments on each edge that loads a valid instruction.
  - perf_bubble_cnt_o [31:0] increments on each edge that loads a bubble.
  - Both reset to 0, wrap at 2^32 and hold during stall.
- FETCH_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- **irmovq**
  - Stimulus: reset; mem[0..9] = 30 F0 00 01 00 00 00 00 00 00.
  - Response: first edge gives valid 1, icode 3, ifun 0, rA F, rB 0, valC 0x100, valP 10, stat AOK; then imem_addr_o = 10.
- **Jump prediction**
  - Stimulus: jmp at 0x20 = 70 40 00…00.
  - Response: pred_pc_o 0x40, d_valP_o 0x29, next imem_addr_o 0x40.
- **ret then redirect**
  - Stimulus: ret (90) at 0x40; hold for 3 cycles, then redirect to 0x60.
  - Response: icode 9 loaded, then 3 bubbles with PC held at 0x41; next edge bubble, PC 0x60; following edge the 0x60 instruction is valid.
- **Stall and bubble**
  - Stimulus: stall_i high 2 cycles; then bubble_i alone for 1 cycle.
  - Response: during stall, d_* and imem_addr_o are unchanged. The bubble_i cycle loads a bubble while PC advances by the fetched instruction's length.
- **Faults**
  - Stimulus and response:
    - byte 00 gives stat HLT, valid 1, then bubbles with PC frozen.
    - imem_error_i gives stat ADR.
    - byte C0 gives stat INS with icode C.
  - Each fault enters HALT; a redirect returns to RUN.
- **Simultaneous redirect and stall**
  - Stimulus: redirect_valid_i and stall_i high on the same edge.
  - Response: PC = redirect_pc_i and a bubble is loaded. With FETCH_PERF_CNT_EN, perf_bubble_cnt_o increments by 1.
